add_sched: RTL and testbench

- Round-robin scheduler that shares one instance of the team's 64-bit ripple adder `sixtyfourbit` between NREQ requesters.
- Each requester presents a, b and cin with a valid/ready handshake.
- The block grants one requester, registers its operands and drives them through the shared adder.
- It returns the registered sum and carry tagged with the requester id, using a valid/ready response handshake.
- It sits between the client blocks and the single shared adder datapath.

---
 rtl/add_sched_pkg.sv | 10 +
 rtl/add_sched_rr_arbiter.sv | 29 ++
 rtl/sixtyfourbit.sv | 21 ++
 rtl/add_sched.sv | 108 ++++++++++
 tb/tb_add_sched.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/add_sched_pkg.sv
// add_sched_pkg: FSM state type, datapath width and round-robin pointer helper shared by add_sched
package add_sched_pkg;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    localparam int DATA_W = 64;

    function automatic int rr_next(input int idx, input int nreq);
        return (idx + 1 == nreq) ? 0 : idx + 1;
    endfunction
endpackage

// File: rtl/add_sched_rr_arbiter.sv
// rr_arbiter: round-robin arbiter searching circularly from ptr
//   req : request vector   ptr : highest-priority index   en : grant allowed
//   gnt : one-hot grant (0 when en low or no request)   idx : encoded grantee
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] idx
);
    logic [ID_W-1:0] j;

    // Walk from farthest to nearest so the candidate closest to ptr is the last one written.
    always_comb begin
        gnt = '0;
        idx = '0;
        j = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % NREQ);
            if (en && req[j]) begin
                gnt = NREQ'(1) << j;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/sixtyfourbit.sv
// sixtyfourbit: 64-bit ripple-carry adder
//   a, b : operands   cin : carry-in   sum : a+b+cin mod 2^64   cout : carry out of bit 63
module sixtyfourbit (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        cin,
    output logic [63:0] sum,
    output logic        cout
);
    logic c;

    always_comb begin
        c = cin;
        sum = '0;
        for (int k = 0; k < 64; k++) begin
            sum[k] = a[k] ^ b[k] ^ c;
            c = (a[k] & b[k]) | (c & (a[k] ^ b[k]));
        end
        cout = c;
    end
endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one sixtyfourbit adder between NREQ requesters
//   req_valid/req_ready/req_a/req_b/req_cin : per-requester operand handshake (64-bit lanes)
//   rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_carry : tagged result handshake
//   busy : FSM not idle
//   ADD_SCHED_OVF_EN : adds rsp_ovf, registered signed overflow of the result
module add_sched
    import add_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_carry,
    output logic                   busy
`ifdef ADD_SCHED_OVF_EN
    ,
    output logic                   rsp_ovf
`endif
);
    state_t state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_idx, op_id_q, id_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, add_sum, sum_q;
    logic [NREQ-1:0] gnt;
    logic op_cin_q, add_cout, carry_q, take, elig;

    // rst gates eligibility so req_ready reads 0 while reset is held.
    assign elig = !rst && (state_q == IDLE || (state_q == DONE && rsp_ready));

    rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .req(req_valid),
        .ptr(rr_ptr_q),
        .en (elig),
        .gnt(gnt),
        .idx(gnt_idx)
    );

    sixtyfourbit u_add (
        .a   (op_a_q),
        .b   (op_b_q),
        .cin (op_cin_q),
        .sum (add_sum),
        .cout(add_cout)
    );

    assign take = |gnt;
    assign req_ready = gnt;
    assign rsp_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign rsp_id = id_q;
    assign rsp_sum = sum_q;
    assign rsp_carry = carry_q;

    always_comb begin
        state_d = take ? ADD : state_q == ADD ? DONE : (state_q == DONE && !rsp_ready) ? DONE : IDLE;
        rr_ptr_d = take ? ID_W'(rr_next(int'(gnt_idx), NREQ)) : rr_ptr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_ptr_q <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            op_cin_q <= 1'b0;
            op_id_q <= '0;
            sum_q <= '0;
            carry_q <= 1'b0;
            id_q <= '0;
        end else begin
            state_q <= state_d;
            rr_ptr_q <= rr_ptr_d;
            if (take) begin
                op_a_q <= req_a[DATA_W*int'(gnt_idx) +: DATA_W];
                op_b_q <= req_b[DATA_W*int'(gnt_idx) +: DATA_W];
                op_cin_q <= req_cin[gnt_idx];
                op_id_q <= gnt_idx;
            end
            if (state_q == ADD) begin
                sum_q <= add_sum;
                carry_q <= add_cout;
                id_q <= op_id_q;
            end
        end
    end

`ifdef ADD_SCHED_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (state_q == ADD)
            ovf_q <= (op_a_q[DATA_W-1] == op_b_q[DATA_W-1]) && (add_sum[DATA_W-1] != op_a_q[DATA_W-1]);
    end

    assign rsp_ovf = ovf_q;
`endif
endmodule

// File: tb/tb_add_sched.sv
// tb_add_sched: directed and random checks of add_sched against a transaction-level model
module tb_add_sched;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_cin = '0;
    logic [N-1:0] req_ready;
    logic [N*64-1:0] req_a = '0;
    logic [N*64-1:0] req_b = '0;
    logic rsp_valid, rsp_carry, busy;
    logic rsp_ready = 1'b1;
    logic [1:0] rsp_id;
    logic [63:0] rsp_sum;
`ifdef ADD_SCHED_OVF_EN
    logic rsp_ovf;
`endif

    int total = 0;
    int bad = 0;
    int ms = 0, mptr = 0, mid = 0, rid = 0;
    logic [63:0] ma = '0, mb = '0, rsum = '0;
    logic mc = 1'b0, rc = 1'b0, ro = 1'b0;
    int ids[$];
    int fexp[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    add_sched #(.NREQ(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_cin  (req_cin),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .rsp_sum  (rsp_sum),
        .rsp_carry(rsp_carry),
        .busy     (busy)
`ifdef ADD_SCHED_OVF_EN
        ,
        .rsp_ovf  (rsp_ovf)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic setop(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
        req_a[64*i +: 64] = a;
        req_b[64*i +: 64] = b;
        req_cin[i] = c;
    endtask

    task automatic randops();
        for (int i = 0; i < N; i++)
            setop(i, {$urandom, $urandom}, ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {$urandom, $urandom}, 1'($urandom));
    endtask

    // One clock: check the grant against the arbitration rule, advance the model, check outputs.
    task automatic step();
        int g = -1;
        logic [64:0] s;
        logic fresh = 1'b0;
        #1;
        if (!rst && (ms == 0 || (ms == 2 && rsp_ready)))
            for (int k = 0; k < N; k++)
                if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
        chk("req_ready", 64'(req_ready), g < 0 ? 64'd0 : 64'd1 << g);
        @(posedge clk);
        if (g >= 0) begin
            ma = req_a[64*g +: 64];
            mb = req_b[64*g +: 64];
            mc = req_cin[g];
            mid = g;
            mptr = (g + 1) % N;
            ms = 1;
        end else if (ms == 1) begin
            s = {1'b0, ma} + {1'b0, mb} + 65'(mc);
            rsum = s[63:0];
            rc = s[64];
            ro = (ma[63] == mb[63]) && (s[63] != ma[63]);
            rid = mid;
            ms = 2;
            fresh = 1'b1;
        end else if (ms == 2 && rsp_ready) begin
            ms = 0;
        end
        #1;
        chk("rsp_valid", 64'(rsp_valid), 64'(ms == 2));
        chk("busy", 64'(busy), 64'(ms != 0));
        if (ms == 2) begin
            chk("rsp_id", 64'(rsp_id), 64'(rid));
            chk("rsp_sum", rsp_sum, rsum);
            chk("rsp_carry", 64'(rsp_carry), 64'(rc));
`ifdef ADD_SCHED_OVF_EN
            chk("rsp_ovf", 64'(rsp_ovf), 64'(ro));
`endif
            if (fresh) ids.push_back(int'(rsp_id));
        end
    endtask

    initial begin
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_sum", rsp_sum, 64'd0);
        chk("rst_rsp_carry", 64'(rsp_carry), 64'd0);
        rst = 1'b0;
        req_valid = '0;

        setop(2, 64'd5, 64'd7, 1'b1);
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        chk("single_sum", rsp_sum, 64'd13);
        chk("single_carry", 64'(rsp_carry), 64'd0);
        chk("single_id", 64'(rsp_id), 64'd2);
        step();

        setop(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        step();
        chk("wrap_sum", rsp_sum, 64'd0);
        chk("wrap_carry", 64'(rsp_carry), 64'd1);
`ifdef ADD_SCHED_OVF_EN
        chk("wrap_ovf", 64'(rsp_ovf), 64'd0);
`endif
        step();

        setop(3, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        step();
        chk("ovf_sum", rsp_sum, 64'h8000_0000_0000_0000);
`ifdef ADD_SCHED_OVF_EN
        chk("ovf_flag", 64'(rsp_ovf), 64'd1);
`endif
        step();

        ids.delete();
        req_valid = 4'hF;
        repeat (10) begin
            randops();
            step();
        end
        chk("fair_count", 64'(ids.size()), 64'd5);
        for (int k = 0; k < 5 && k < ids.size(); k++)
            chk($sformatf("fair_id%0d", k), 64'(ids[k]), 64'(fexp[k]));

        rsp_ready = 1'b0;
        repeat (5) begin
            randops();
            step();
            chk("bp_sum", rsp_sum, rsum);
            chk("bp_id", 64'(rsp_id), 64'd0);
            chk("bp_valid", 64'(rsp_valid), 64'd1);
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_busy", 64'(busy), 64'd1);

        req_valid = '0;
        repeat (3) step();
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        step();
        step();
        req_valid = 4'b0010;
        step();
        req_valid = '0;
        step();
        rsp_ready = 1'b1;
        step();
        ids.delete();
        repeat (4) step();
        chk("withdrawn_none", 64'(ids.size()), 64'd0);

        req_valid = 4'b0001;
        step();
        req_valid = 4'b0011;
        #2 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        ms = 0;
        mptr = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        req_valid = '0;
        step();
        chk("midrst_tie_id", 64'(rsp_id), 64'd0);
        step();

        repeat (400) begin
            randops();
            req_valid = 4'($urandom);
            rsp_ready = $urandom_range(0, 3) != 0;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
